fifo_uart: RTL and testbench

FIFO_UART -- requirements
Module: fifo_uart

---
 rtl/fifo_uart_if.sv | 30 +++
 rtl/fifo_uart.sv | 202 ++++++++++++++++++++
 tb/tb_fifo_uart.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_if.sv
// rtl/fifo_uart_if.sv - FIFO push/pop and UART serial/byte signal bundle
interface fifo_uart_if #(parameter int WIDTH = 8);
    logic             rd;
    logic             wr;
    logic [WIDTH-1:0] input_data;
    logic [WIDTH-1:0] output_data;
    logic             empty;
    logic             full;
    logic             rx;
    logic             transmit;
    logic [7:0]       tx_byte;
    logic             tx;
    logic             received;
    logic [7:0]       rx_byte;
    logic             is_receiving;
    logic             is_transmitting;
    logic             recv_error;

    modport master (
        output rd, wr, input_data, rx, transmit, tx_byte,
        input  output_data, empty, full, tx, received, rx_byte,
               is_receiving, is_transmitting, recv_error
    );

    modport slave (
        input  rd, wr, input_data, rx, transmit, tx_byte,
        output output_data, empty, full, tx, received, rx_byte,
               is_receiving, is_transmitting, recv_error
    );
endinterface

// File: rtl/fifo_uart.sv
// rtl/fifo_uart.sv - first-word fall-through FIFO plus independent 8N1 UART TX/RX
module fifo_uart #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int CLOCK_DIVIDE = 108
) (
    input  logic       clk,
    input  logic       rst,
    fifo_uart_if.slave bus
);
    localparam int            AW         = $clog2(DEPTH);
    localparam int            DW         = $clog2(CLOCK_DIVIDE + 1);
    localparam logic [DW-1:0] DIV_LAST   = DW'(CLOCK_DIVIDE - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    wptr;
    logic [AW:0]      count;
    logic             do_rd;
    logic             do_wr;

    assign bus.empty       = (count == '0);
    assign bus.full        = (count == FULL_COUNT);
    assign do_rd           = bus.rd && !bus.empty;
    // At full a simultaneous pop frees the slot the push lands in.
    assign do_wr           = bus.wr && (!bus.full || bus.rd);
    assign bus.output_data = bus.empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= bus.input_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (do_rd && !do_wr) count <= count - 1'b1;
        end
    end

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    tx_state_t     tx_state;
    tx_state_t     tx_next;
    logic [DW-1:0] tx_div;
    logic [1:0]    tx_tcnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;
    logic          tx_bit_done;
    logic          tx_line;
    logic          tx_busy;

    assign tx_bit_done = (tx_div == DIV_LAST) && (tx_tcnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (bus.transmit) tx_next = TX_START;
            TX_START: if (tx_bit_done) tx_next = TX_DATA;
            TX_DATA:  if (tx_bit_done && tx_bit == 3'd7) tx_next = TX_STOP;
            TX_STOP:  if (tx_bit_done) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_line = 1'b1;
        tx_busy = (tx_state != TX_IDLE);
        case (tx_state)
            TX_START: tx_line = 1'b0;
            TX_DATA:  tx_line = tx_shift[0];
            default:  tx_line = 1'b1;
        endcase
    end

    assign bus.tx              = tx_line;
    assign bus.is_transmitting = tx_busy;

    // Divider restarts with each frame so every bit is exactly 4*CLOCK_DIVIDE cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_div   <= '0;
            tx_tcnt  <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_state == TX_IDLE) begin
            tx_div  <= '0;
            tx_tcnt <= '0;
            tx_bit  <= '0;
            if (bus.transmit) tx_shift <= bus.tx_byte;
        end else begin
            tx_div <= (tx_div == DIV_LAST) ? '0 : tx_div + 1'b1;
            if (tx_div == DIV_LAST) tx_tcnt <= tx_tcnt + 1'b1;
            if (tx_bit_done && tx_state == TX_DATA) begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 1'b1;
            end
        end
    end

    typedef enum logic [1:0] {RX_IDLE, RX_START_CHECK, RX_DATA, RX_STOP} rx_state_t;
    rx_state_t     rx_state;
    rx_state_t     rx_next;
    logic          rx_s1;
    logic          rx_s2;
    logic          rx_s3;
    logic [DW-1:0] rx_div;
    logic [1:0]    rx_tcnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_byte_q;
    logic          received_q;
    logic          recv_error_q;
    logic          rx_tick;
    logic          rx_fall;
    logic          rx_mid;
    logic          rx_bit_done;
    logic          rx_busy;

    assign rx_tick     = (rx_div == DIV_LAST);
    assign rx_fall     = rx_s3 && !rx_s2;
    assign rx_mid      = rx_tick && (rx_tcnt == 2'd1);
    assign rx_bit_done = rx_tick && (rx_tcnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:        if (rx_fall) rx_next = RX_START_CHECK;
            RX_START_CHECK: if (rx_mid) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:        if (rx_bit_done && rx_bit == 3'd7) rx_next = RX_STOP;
            RX_STOP:        if (rx_bit_done) rx_next = RX_IDLE;
            default:        rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_busy = (rx_state != RX_IDLE);
    end

    assign bus.is_receiving = rx_busy;
    assign bus.rx_byte      = rx_byte_q;
    assign bus.received     = received_q;
    assign bus.recv_error   = recv_error_q;

    // Synchroniser resets high so reset release never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1        <= 1'b1;
            rx_s2        <= 1'b1;
            rx_s3        <= 1'b1;
            rx_div       <= '0;
            rx_tcnt      <= '0;
            rx_bit       <= '0;
            rx_shift     <= '0;
            rx_byte_q    <= '0;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
        end else begin
            rx_s1        <= bus.rx;
            rx_s2        <= rx_s1;
            rx_s3        <= rx_s2;
            received_q   <= 1'b0;
            recv_error_q <= 1'b0;
            if (rx_state == RX_IDLE) begin
                rx_div  <= '0;
                rx_tcnt <= '0;
                rx_bit  <= '0;
            end else begin
                rx_div <= rx_tick ? '0 : rx_div + 1'b1;
                if (rx_state == RX_START_CHECK && rx_mid) rx_tcnt <= '0;
                else if (rx_tick)                          rx_tcnt <= rx_tcnt + 1'b1;
                if (rx_state == RX_DATA && rx_bit_done) begin
                    rx_shift <= {rx_s2, rx_shift[7:1]};
                    rx_bit   <= rx_bit + 1'b1;
                end
                if (rx_state == RX_STOP && rx_bit_done) begin
                    if (rx_s2) begin
                        rx_byte_q  <= rx_shift;
                        received_q <= 1'b1;
                    end else begin
                        recv_error_q <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_uart.sv
// tb/tb_fifo_uart.sv - randomized self-checking bench for fifo_uart against a queue/frame model
module tb_fifo_uart;
    localparam int DEPTH = 8;
    localparam int CDIV  = 2;

    logic clk = 1'b0;
    logic rst;
    logic rx_drive;
    logic loopback;
    int   errors = 0;
    int   checks = 0;
    int   rcv_cnt = 0;
    int   err_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] rx_exp;

    always #5 clk = ~clk;

    fifo_uart_if #(.WIDTH(8)) bus();

    fifo_uart #(.WIDTH(8), .DEPTH(DEPTH), .CLOCK_DIVIDE(CDIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.rx = loopback ? bus.tx : rx_drive;

    always @(negedge clk) begin
        if (bus.received === 1'b1)   rcv_cnt++;
        if (bus.recv_error === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fifo_op(input logic r, input logic w, input logic [7:0] d);
        logic was_full;
        logic was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        bus.rd = r;
        bus.wr = w;
        bus.input_data = d;
        @(posedge clk); #1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        if (r && !was_empty) void'(q.pop_front());
        if (w && (!was_full || r)) q.push_back(d);
        check("fifo_empty", bus.empty, q.size() == 0);
        check("fifo_full", bus.full, q.size() == DEPTH);
        check("fifo_head", bus.output_data, (q.size() != 0) ? q[0] : 8'h00);
    endtask

    task automatic fifo_random(input int n, input int wp, input int rp);
        logic r;
        logic w;
        for (int i = 0; i < n; i++) begin
            w = ($urandom_range(0, 99) < wp);
            r = ($urandom_range(0, 99) < rp);
            fifo_op(r, w, 8'($urandom));
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit poke);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        bus.tx_byte = b;
        bus.transmit = 1'b1;
        @(posedge clk); #1;
        bus.transmit = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (poke && k == 20) begin
                bus.transmit = 1'b1;
                bus.tx_byte = ~b;
            end else begin
                bus.transmit = 1'b0;
            end
            check($sformatf("tx_bit%0d", k / 8), {bus.is_transmitting, bus.tx}, {1'b1, frame[k / 8]});
            @(posedge clk); #1;
        end
        bus.transmit = 1'b0;
        check("tx_idle", {bus.is_transmitting, bus.tx}, 2'b01);
    endtask

    task automatic loop_frame(input logic [7:0] b, input bit poke);
        int r0;
        int e0;
        r0 = rcv_cnt;
        e0 = err_cnt;
        send_frame(b, poke);
        repeat (12) @(posedge clk);
        #1;
        rx_exp = b;
        check("loop_received", rcv_cnt - r0, 1);
        check("loop_error", err_cnt - e0, 0);
        check("loop_byte", bus.rx_byte, rx_exp);
    endtask

    task automatic rx_case(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        int r0;
        int e0;
        r0 = rcv_cnt;
        e0 = err_cnt;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drive = frame[i];
            repeat (4 * CDIV) @(posedge clk);
            #1;
        end
        rx_drive = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        if (stop) rx_exp = b;
        check("rx_received", rcv_cnt - r0, stop ? 1 : 0);
        check("rx_ferr", err_cnt - e0, stop ? 0 : 1);
        check("rx_byte", bus.rx_byte, rx_exp);
        check("rx_idle", bus.is_receiving, 1'b0);
    endtask

    initial begin
        int   r0;
        int   e0;
        logic saw;
        rst = 1'b1;
        rx_drive = 1'b1;
        loopback = 1'b0;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.input_data = '0;
        bus.transmit = 1'b0;
        bus.tx_byte = '0;
        rx_exp = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_empty", bus.empty, 1'b1);
        check("rst_full", bus.full, 1'b0);
        check("rst_head", bus.output_data, 8'h00);
        check("rst_tx", bus.tx, 1'b1);
        check("rst_busy", {bus.is_transmitting, bus.is_receiving}, 2'b00);
        check("rst_pulses", {bus.received, bus.recv_error}, 2'b00);
        check("rst_rx_byte", bus.rx_byte, 8'h00);
        rst = 1'b0;

        fifo_op(1'b1, 1'b0, 8'h00);
        fifo_op(1'b0, 1'b1, 8'h11);
        fifo_op(1'b0, 1'b1, 8'h22);
        fifo_op(1'b0, 1'b1, 8'h33);
        check("three_head", bus.output_data, 8'h11);
        for (int i = 0; i < 3; i++) fifo_op(1'b1, 1'b0, 8'h00);
        check("three_drained", {bus.empty, bus.output_data}, 9'h100);

        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < DEPTH; i++) fifo_op(1'b0, 1'b1, 8'($urandom));
            check("fill_full", bus.full, 1'b1);
            fifo_op(1'b0, 1'b1, 8'hFF);
            fifo_op(1'b1, 1'b1, 8'hAB);
            fifo_op(1'b1, 1'b1, 8'($urandom));
            for (int i = 0; i < DEPTH; i++) fifo_op(1'b1, 1'b0, 8'h00);
            fifo_op(1'b1, 1'b1, 8'h5A);
            fifo_op(1'b1, 1'b0, 8'h00);
        end
        fifo_random(150, 70, 30);
        fifo_random(150, 30, 70);

        rx_case(8'h3C, 1'b0);
        for (int i = 0; i < 3; i++) rx_case(8'($urandom), 1'b1);
        rx_case(8'h3C, 1'b0);
        rx_case(8'($urandom), 1'($urandom_range(0, 1)));

        r0 = rcv_cnt;
        e0 = err_cnt;
        saw = 1'b0;
        rx_drive = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx_drive = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (bus.is_receiving) saw = 1'b1;
            @(posedge clk); #1;
        end
        check("glitch_started", saw, 1'b1);
        check("glitch_idle", bus.is_receiving, 1'b0);
        check("glitch_pulses", (rcv_cnt - r0) + (err_cnt - e0), 0);

        loopback = 1'b1;
        loop_frame(8'h41, 1'b0);
        loop_frame(8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) loop_frame(8'($urandom), 1'b0);
        fork
            loop_frame(8'($urandom), 1'b0);
            fifo_random(100, 50, 50);
        join

        r0 = rcv_cnt;
        e0 = err_cnt;
        bus.tx_byte = 8'h55;
        bus.transmit = 1'b1;
        @(posedge clk); #1;
        bus.transmit = 1'b0;
        repeat ($urandom_range(20, 60)) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        rx_exp = 8'h00;
        check("abort_tx", {bus.is_transmitting, bus.tx}, 2'b01);
        check("abort_rx", bus.is_receiving, 1'b0);
        check("abort_fifo", {bus.empty, bus.full}, 2'b10);
        check("abort_rx_byte", bus.rx_byte, rx_exp);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_pulse", (rcv_cnt - r0) + (err_cnt - e0), 0);
        loop_frame(8'h55, 1'b0);
        fifo_random(40, 60, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
